i2c_slave_regfile: RTL and testbench

//  Bus-side I2C target for the I2C master receive engine. Decodes START/Sr/STOP, matches a 7-bit

---
 rtl/i2c_slave_regfile.sv | 212 +++++++++++++++++++++
 tb/tb_i2c_slave_regfile.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regfile.sv
// I2C target with a 2**REG_AW-byte register file, auto-incrementing pointer and a local host port.
// Optional SCL stretching after each driven ACK when I2C_SLV_CLK_STRETCH_EN is defined.
module i2c_slave_regfile #(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int         REG_AW   = 8,
  parameter int         STRETCH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_scl,
  input  logic              i_sda,
  output logic              o_sda_oe,
  output logic              o_scl_oe,
  input  logic              i_host_we,
  input  logic [REG_AW-1:0] i_host_addr,
  input  logic [7:0]        i_host_wdata,
  output logic [7:0]        o_host_rdata,
  output logic              o_busy,
  output logic [2:0]        o_state
);

  // state    | meaning
  // IDLE     | bus free or not yet addressed
  // DEV_ADDR | shifting device address + R/W
  // ACK      | driving ACK low for one SCL period
  // REG_ADDR | shifting register pointer
  // WR_DATA  | shifting write data, store on 8th bit
  // RD_DATA  | driving read data MSB first
  // RD_ACK   | sampling master ACK/NACK
  // IGNORE   | not addressed or NACKed, wait for START/STOP
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DEV_ADDR = 3'd1,
    S_ACK      = 3'd2,
    S_REG_ADDR = 3'd3,
    S_WR_DATA  = 3'd4,
    S_RD_DATA  = 3'd5,
    S_RD_ACK   = 3'd6,
    S_IGNORE   = 3'd7
  } state_t;

  logic              scl_s1, scl_s2, scl_h, sda_s1, sda_s2, sda_h;
  logic              scl_rise, scl_fall, start_det, stop_det;
  state_t            state, state_n, ack_to, ack_to_n;
  logic [3:0]        bit_cnt, bit_cnt_n;
  logic [7:0]        shreg, shreg_n, tx, tx_n, byte_in, rd_byte;
  logic [REG_AW-1:0] ptr, ptr_n;
  logic              sda_oe, sda_oe_n, busy, busy_n, bus_we;
  logic [7:0]        mem [2**REG_AW];

  // Synchronisers reset to the idle-bus level so reset release creates no false START/STOP
  always_ff @(posedge clk) begin
    if (rst) begin
      {scl_s1, scl_s2, scl_h} <= 3'b111;
      {sda_s1, sda_s2, sda_h} <= 3'b111;
    end else begin
      {scl_s1, scl_s2, scl_h} <= {i_scl, scl_s1, scl_s2};
      {sda_s1, sda_s2, sda_h} <= {i_sda, sda_s1, sda_s2};
    end
  end

  assign scl_rise  = scl_s2 & ~scl_h;
  assign scl_fall  = ~scl_s2 & scl_h;
  assign start_det = scl_s2 & scl_h & sda_h & ~sda_s2;
  assign stop_det  = scl_s2 & scl_h & ~sda_h & sda_s2;
  assign byte_in   = {shreg[6:0], sda_s2};
  assign rd_byte   = mem[ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      ack_to  <= S_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      tx      <= '0;
      ptr     <= '0;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      ack_to  <= ack_to_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      tx      <= tx_n;
      ptr     <= ptr_n;
      sda_oe  <= sda_oe_n;
      busy    <= busy_n;
    end
  end

  always_comb begin
    state_n   = state;
    ack_to_n  = ack_to;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    tx_n      = tx;
    ptr_n     = ptr;
    sda_oe_n  = sda_oe;
    busy_n    = busy;
    bus_we    = 1'b0;
    if (start_det) begin
      state_n   = S_DEV_ADDR;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
    end else if (stop_det) begin
      state_n   = S_IDLE;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b0;
    end else begin
      case (state)
        S_DEV_ADDR, S_REG_ADDR, S_WR_DATA: begin
          if (scl_rise && bit_cnt != 4'd8) begin
            shreg_n   = byte_in;
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7 && state == S_REG_ADDR) ptr_n = byte_in[REG_AW-1:0];
            if (bit_cnt == 4'd7 && state == S_WR_DATA) begin
              bus_we = 1'b1;
              ptr_n  = ptr + REG_AW'(1);
            end
          end else if (scl_fall && bit_cnt == 4'd8) begin
            bit_cnt_n = '0;
            if (state == S_DEV_ADDR && shreg[7:1] != DEV_ADDR) begin
              state_n = S_IGNORE;
            end else begin
              sda_oe_n = 1'b1;
              state_n  = S_ACK;
              if (state == S_DEV_ADDR) begin
                busy_n   = 1'b1;
                ack_to_n = shreg[0] ? S_RD_DATA : S_REG_ADDR;
              end else begin
                ack_to_n = S_WR_DATA;
              end
            end
          end
        end
        S_ACK: begin
          if (scl_fall) begin
            state_n = ack_to;
            if (ack_to == S_RD_DATA) begin
              // first read bit goes out on the same fall that ends the ACK slot
              sda_oe_n = ~rd_byte[7];
              tx_n     = {rd_byte[6:0], 1'b0};
            end else begin
              sda_oe_n = 1'b0;
            end
          end
        end
        S_RD_DATA: begin
          if (scl_rise && bit_cnt != 4'd8) begin
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) ptr_n = ptr + REG_AW'(1);
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe_n  = 1'b0;
              bit_cnt_n = '0;
              state_n   = S_RD_ACK;
            end else begin
              sda_oe_n = ~tx[7];
              tx_n     = {tx[6:0], 1'b0};
            end
          end
        end
        S_RD_ACK: begin
          if (scl_rise) begin
            if (!sda_s2) begin
              tx_n    = rd_byte;
              state_n = S_RD_DATA;
            end else begin
              state_n = S_IGNORE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Bus write is assigned last so it wins a same-address collision with the host
  always_ff @(posedge clk) begin
    if (i_host_we) mem[i_host_addr] <= i_host_wdata;
    if (bus_we && !rst) mem[ptr] <= byte_in;
  end

  always_ff @(posedge clk) begin
    if (rst) o_host_rdata <= '0;
    else     o_host_rdata <= mem[i_host_addr];
  end

`ifdef I2C_SLV_CLK_STRETCH_EN
  localparam int SW = $clog2(STRETCH + 1);
  logic          ack_end;
  logic [SW-1:0] stretch_cnt;

  assign ack_end = (state == S_ACK) && scl_fall;

  always_ff @(posedge clk) begin
    if (rst)                    stretch_cnt <= '0;
    else if (ack_end)           stretch_cnt <= SW'(STRETCH);
    else if (stretch_cnt != '0) stretch_cnt <= stretch_cnt - SW'(1);
  end

  assign o_scl_oe = (stretch_cnt != '0);
`else
  assign o_scl_oe = (STRETCH < 0);
`endif

  assign o_sda_oe = sda_oe;
  assign o_busy   = busy;
  assign o_state  = state;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile: open-drain bus master model plus a transaction-level register model.
module tb_i2c_slave_regfile;
  localparam logic [6:0] DEV = 7'h50;
  localparam int Q = 6;
  typedef logic [7:0] byte4_t [4];

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_m, sda_m, scl_bus, sda_bus;
  logic       o_sda_oe, o_scl_oe, o_busy;
  logic       i_host_we;
  logic [7:0] i_host_addr, i_host_wdata, o_host_rdata;
  logic [2:0] o_state;

  int tests_run = 0;
  int tests_failed = 0;
  int sda_seen = 0;
  int scl_oe_cycles = 0;
  logic [7:0] ref_mem [256];
  logic [7:0] ref_ptr;

  always #5 clk = ~clk;

  assign scl_bus = scl_m & ~o_scl_oe;
  assign sda_bus = sda_m & ~o_sda_oe;

  i2c_slave_regfile dut (
    .clk(clk), .rst(rst), .i_scl(scl_bus), .i_sda(sda_bus),
    .o_sda_oe(o_sda_oe), .o_scl_oe(o_scl_oe),
    .i_host_we(i_host_we), .i_host_addr(i_host_addr), .i_host_wdata(i_host_wdata),
    .o_host_rdata(o_host_rdata), .o_busy(o_busy), .o_state(o_state)
  );

  always @(posedge clk) begin
    if (o_sda_oe === 1'b1) sda_seen++;
    if (o_scl_oe === 1'b1) scl_oe_cycles++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time exceeded, tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic scl_high();
    int t;
    scl_m = 1'b1;
    t = 0;
    while (scl_bus !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      tests_run++; tests_failed++;
      $display("FAIL scl_release: scl=%b expected 1", scl_bus);
    end
  endtask

  task automatic put_bit(input logic b);
    scl_m = 1'b0; clks(Q);
    sda_m = b;    clks(Q);
    scl_high();   clks(2*Q);
  endtask

  task automatic get_bit(output logic b);
    scl_m = 1'b0; clks(Q);
    sda_m = 1'b1; clks(Q);
    scl_high();   clks(Q);
    b = sda_bus;  clks(Q);
  endtask

  task automatic start_cond();
    scl_m = 1'b0; clks(Q);
    sda_m = 1'b1; clks(Q);
    scl_high();   clks(2*Q);
    sda_m = 1'b0; clks(2*Q);
  endtask

  task automatic stop_cond();
    scl_m = 1'b0; clks(Q);
    sda_m = 1'b0; clks(Q);
    scl_high();   clks(2*Q);
    sda_m = 1'b1; clks(2*Q);
  endtask

  // collide: host writes 8'hA5 to 8'h20 in the exact cycle the DUT stores the bus byte
  task automatic send_byte(input logic [7:0] b, input bit collide, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      if (collide && i == 0) begin
        scl_m = 1'b0; clks(Q);
        sda_m = b[0]; clks(Q);
        scl_m = 1'b1; clks(2);
        i_host_addr = 8'h20; i_host_wdata = 8'hA5; i_host_we = 1'b1;
        clks(1);
        i_host_we = 1'b0;
        clks(2*Q - 3);
      end else begin
        put_bit(b[i]);
      end
    end
    get_bit(ack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] b);
    logic x;
    for (int i = 7; i >= 0; i--) begin
      get_bit(x);
      b[i] = x;
    end
    put_bit(nack);
  endtask

  task automatic host_write(input logic [7:0] a, input logic [7:0] d);
    i_host_addr = a; i_host_wdata = d; i_host_we = 1'b1;
    clks(1);
    i_host_we = 1'b0;
  endtask

  task automatic host_read(input logic [7:0] a, output logic [7:0] d);
    i_host_addr = a;
    clks(1);
    d = o_host_rdata;
  endtask

  task automatic bus_write(input logic [7:0] ra, input byte4_t d, input int n, output int nacks);
    logic a;
    nacks = 0;
    start_cond();
    send_byte({DEV, 1'b0}, 1'b0, a); nacks += int'(a);
    send_byte(ra, 1'b0, a);          nacks += int'(a);
    for (int i = 0; i < n; i++) begin
      send_byte(d[i], 1'b0, a);      nacks += int'(a);
    end
    stop_cond();
    for (int i = 0; i < n; i++) ref_mem[8'(ra + i)] = d[i];
    ref_ptr = 8'(ra + n);
  endtask

  task automatic bus_read(input bit set_ptr, input logic [7:0] ra, input int n,
                          output byte4_t q, output int nacks);
    logic a;
    nacks = 0;
    start_cond();
    if (set_ptr) begin
      send_byte({DEV, 1'b0}, 1'b0, a); nacks += int'(a);
      send_byte(ra, 1'b0, a);          nacks += int'(a);
      start_cond();
    end
    send_byte({DEV, 1'b1}, 1'b0, a);   nacks += int'(a);
    for (int i = 0; i < n; i++) recv_byte(i == n - 1, q[i]);
    stop_cond();
  endtask

  task automatic test_reset();
    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    i_host_we = 1'b0; i_host_addr = '0; i_host_wdata = '0;
    clks(4);
    tests_run++;
    if ({o_sda_oe, o_scl_oe, o_busy} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_ctl: sda_oe/scl_oe/busy=%b expected 000", {o_sda_oe, o_scl_oe, o_busy});
    end
    tests_run++;
    if (o_state !== 3'd0) begin
      tests_failed++; $display("FAIL reset_state: got %0d expected 0", o_state);
    end
    tests_run++;
    if (o_host_rdata !== 8'h00) begin
      tests_failed++; $display("FAIL reset_rdata: got %h expected 00", o_host_rdata);
    end
    rst = 1'b0;
    ref_ptr = 8'h00;
    clks(4);
  endtask

  task automatic test_host_port();
    logic [7:0] a, d;
    for (int i = 0; i < 256; i++) begin
      d = 8'($urandom);
      host_write(8'(i), d);
      ref_mem[i] = d;
    end
    for (int k = 0; k < 4; k++) begin
      a = 8'($urandom);
      host_read(a, d);
      tests_run++;
      if (d !== ref_mem[a]) begin
        tests_failed++; $display("FAIL host_read[%h]: got %h expected %h", a, d, ref_mem[a]);
      end
    end
  endtask

  task automatic test_write();
    logic a;
    logic [7:0] d;
    int nk;
    start_cond();
    send_byte(8'hA0, 1'b0, a);
    tests_run++;
    if ({a, o_busy, o_state} !== {1'b0, 1'b1, 3'd2}) begin
      tests_failed++;
      $display("FAIL wr_addr_ack: ack/busy/state=%b/%b/%0d expected 0/1/2", a, o_busy, o_state);
    end
    nk = 0;
    send_byte(8'h10, 1'b0, a); nk += int'(a);
    send_byte(8'h5A, 1'b0, a); nk += int'(a);
    send_byte(8'h3C, 1'b0, a); nk += int'(a);
    tests_run++;
    if (nk !== 0 || o_busy !== 1'b1) begin
      tests_failed++; $display("FAIL wr_acks: nacks=%0d busy=%b expected 0 and 1", nk, o_busy);
    end
    stop_cond();
    tests_run++;
    if (o_busy !== 1'b0 || o_state !== 3'd0) begin
      tests_failed++; $display("FAIL wr_stop: busy=%b state=%0d expected 0/0", o_busy, o_state);
    end
    ref_mem[8'h10] = 8'h5A; ref_mem[8'h11] = 8'h3C; ref_ptr = 8'h12;
    host_read(8'h10, d);
    tests_run++;
    if (d !== 8'h5A) begin tests_failed++; $display("FAIL wr_mem10: got %h expected 5a", d); end
    host_read(8'h11, d);
    tests_run++;
    if (d !== 8'h3C) begin tests_failed++; $display("FAIL wr_mem11: got %h expected 3c", d); end
  endtask

  task automatic test_random_read();
    logic a;
    logic [7:0] b0, b1;
    int nk;
    nk = 0;
    start_cond();
    send_byte(8'hA0, 1'b0, a); nk += int'(a);
    send_byte(8'h10, 1'b0, a); nk += int'(a);
    start_cond();
    send_byte(8'hA1, 1'b0, a); nk += int'(a);
    recv_byte(1'b0, b0);
    recv_byte(1'b1, b1);
    tests_run++;
    if (nk !== 0 || b0 !== 8'h5A || b1 !== 8'h3C) begin
      tests_failed++;
      $display("FAIL rd_random: nacks=%0d data=%h %h expected 0, 5a 3c", nk, b0, b1);
    end
    tests_run++;
    if (o_state !== 3'd7 || o_sda_oe !== 1'b0) begin
      tests_failed++;
      $display("FAIL rd_nack_release: state=%0d sda_oe=%b expected 7/0", o_state, o_sda_oe);
    end
    stop_cond();
    ref_ptr = 8'h12;
  endtask

  task automatic test_miss();
    logic a;
    logic [7:0] d;
    int acks;
    acks = 0;
    sda_seen = 0;
    start_cond();
    send_byte(8'hA2, 1'b0, a); acks += int'(!a);
    tests_run++;
    if (o_state !== 3'd7) begin
      tests_failed++; $display("FAIL miss_state: got %0d expected 7", o_state);
    end
    send_byte(8'h10, 1'b0, a); acks += int'(!a);
    send_byte(8'h77, 1'b0, a); acks += int'(!a);
    tests_run++;
    if (o_state !== 3'd7 || o_busy !== 1'b0) begin
      tests_failed++; $display("FAIL miss_hold: state=%0d busy=%b expected 7/0", o_state, o_busy);
    end
    stop_cond();
    tests_run++;
    if (sda_seen !== 0 || acks !== 0) begin
      tests_failed++; $display("FAIL miss_sda: driven cycles=%0d acks=%0d expected 0/0", sda_seen, acks);
    end
    host_read(8'h10, d);
    tests_run++;
    if (d !== ref_mem[8'h10]) begin
      tests_failed++; $display("FAIL miss_mem: got %h expected %h", d, ref_mem[8'h10]);
    end
  endtask

  task automatic test_wrap();
    byte4_t d, q;
    logic [7:0] r;
    int nk;
    d = '{8'h11, 8'h22, 8'h00, 8'h00};
    bus_write(8'hFF, d, 2, nk);
    host_read(8'hFF, r);
    tests_run++;
    if (nk !== 0 || r !== 8'h11) begin
      tests_failed++; $display("FAIL wrap_ff: nacks=%0d mem=%h expected 0/11", nk, r);
    end
    host_read(8'h00, r);
    tests_run++;
    if (r !== 8'h22) begin tests_failed++; $display("FAIL wrap_00: got %h expected 22", r); end
    bus_read(1'b0, 8'h00, 1, q, nk);
    tests_run++;
    if (nk !== 0 || q[0] !== ref_mem[8'h01]) begin
      tests_failed++; $display("FAIL wrap_cur_read: nacks=%0d got %h expected %h", nk, q[0], ref_mem[8'h01]);
    end
    ref_ptr = 8'h02;
  endtask

  task automatic test_abort();
    logic a;
    logic [7:0] r;
    int nk;
    nk = 0;
    start_cond();
    send_byte(8'hA0, 1'b0, a); nk += int'(a);
    send_byte(8'h40, 1'b0, a); nk += int'(a);
    put_bit(1'b1); put_bit(1'b1); put_bit(1'b0); put_bit(1'b0);
    stop_cond();
    ref_ptr = 8'h40;
    host_read(8'h40, r);
    tests_run++;
    if (nk !== 0 || r !== ref_mem[8'h40]) begin
      tests_failed++; $display("FAIL abort_nowrite: nacks=%0d mem=%h expected 0/%h", nk, r, ref_mem[8'h40]);
    end
    host_write(8'h40, 8'h12);
    ref_mem[8'h40] = 8'h12;
    start_cond();
    send_byte(8'hA1, 1'b0, a);
    scl_m = 1'b0; clks(Q);
    tests_run++;
    if (a !== 1'b0 || o_sda_oe !== 1'b1 || o_state !== 3'd5) begin
      tests_failed++;
      $display("FAIL abort_rd_drive: ack=%b sda_oe=%b state=%0d expected 0/1/5", a, o_sda_oe, o_state);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (o_sda_oe !== 1'b0 || o_state !== 3'd0 || o_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_rst: sda_oe=%b state=%0d busy=%b expected 0/0/0", o_sda_oe, o_state, o_busy);
    end
    @(negedge clk);
    rst = 1'b0;
    sda_m = 1'b1; clks(Q);
    scl_m = 1'b1; clks(2*Q);
    ref_ptr = 8'h00;
  endtask

  task automatic test_collision();
    logic a;
    logic [7:0] r;
    int nk;
    nk = 0;
    start_cond();
    send_byte(8'hA0, 1'b0, a); nk += int'(a);
    send_byte(8'h20, 1'b0, a); nk += int'(a);
    send_byte(8'h5A, 1'b1, a); nk += int'(a);
    stop_cond();
    ref_mem[8'h20] = 8'h5A; ref_ptr = 8'h21;
    host_read(8'h20, r);
    tests_run++;
    if (nk !== 0 || r !== 8'h5A) begin
      tests_failed++; $display("FAIL collision: nacks=%0d mem[20]=%h expected 0/5a", nk, r);
    end
  endtask

  task automatic test_stretch();
    byte4_t d;
    int nk, want;
    d = '{8'h01, 8'h02, 8'h00, 8'h00};
    scl_oe_cycles = 0;
    bus_write(8'h80, d, 2, nk);
`ifdef I2C_SLV_CLK_STRETCH_EN
    want = 4 * 8;
`else
    want = 0;
`endif
    tests_run++;
    if (nk !== 0 || scl_oe_cycles !== want) begin
      tests_failed++; $display("FAIL stretch: nacks=%0d scl_oe cycles=%0d expected 0/%0d", nk, scl_oe_cycles, want);
    end
  endtask

  task automatic test_random();
    byte4_t d, q;
    logic [7:0] ra, p, r;
    int n, nk;
    bit sp;
    for (int it = 0; it < 8; it++) begin
      ra = 8'($urandom);
      n = $urandom_range(1, 4);
      for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
      bus_write(ra, d, n, nk);
      tests_run++;
      if (nk !== 0) begin tests_failed++; $display("FAIL rnd_wr_ack[%0d]: nacks=%0d expected 0", it, nk); end
      sp = 1'($urandom_range(0, 1));
      ra = sp ? 8'($urandom) : ref_ptr;
      n = $urandom_range(1, 4);
      bus_read(sp, ra, n, q, nk);
      p = ra;
      for (int i = 0; i < n; i++) begin
        tests_run++;
        if (q[i] !== ref_mem[p] || nk !== 0) begin
          tests_failed++;
          $display("FAIL rnd_rd[%0d.%0d]: addr=%h got %h expected %h nacks=%0d", it, i, p, q[i], ref_mem[p], nk);
        end
        p = p + 8'd1;
      end
      ref_ptr = p;
      ra = 8'($urandom);
      host_read(ra, r);
      tests_run++;
      if (r !== ref_mem[ra]) begin
        tests_failed++; $display("FAIL rnd_host[%h]: got %h expected %h", ra, r, ref_mem[ra]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_host_port();
    test_write();
    test_random_read();
    test_miss();
    test_wrap();
    test_abort();
    test_collision();
    test_stretch();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
